// File: rtl/msrr_pkg.sv
// msrr_pkg: shared mode and state encodings for the multi-mode shift/rotate register
package msrr_pkg;
  localparam int MODE_W = 3;
  typedef enum logic [MODE_W-1:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_ROR  = 3'b011,
    M_ROL  = 3'b100,
    M_ASR  = 3'b101,
    M_LOAD = 3'b110,
    M_CLR  = 3'b111
  } mode_t;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/msrr_step.sv
// msrr_step: combinational next-value of the register for one operation
module msrr_step
  import msrr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             sIn,
  input  logic [WIDTH-1:0] pIn,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] nextQ
);
  always_comb begin
    nextQ = (mode == M_SHR)  ? {sIn, Q[WIDTH-1:1]} :
            (mode == M_SHL)  ? {Q[WIDTH-2:0], sIn} :
            (mode == M_ROR)  ? {Q[0], Q[WIDTH-1:1]} :
            (mode == M_ROL)  ? {Q[WIDTH-2:0], Q[WIDTH-1]} :
            (mode == M_ASR)  ? {Q[WIDTH-1], Q[WIDTH-1:1]} :
            (mode == M_LOAD) ? pIn :
            (mode == M_CLR)  ? '0 : Q;
  end
endmodule

// File: rtl/msrr_param.sv
// msrr_param: shift/rotate register with single-step and counted burst operation
module msrr_param
  import msrr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clc,
  input  logic             R,
  input  logic             sIn,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  input  logic [WIDTH-1:0] pIn,
  output logic [WIDTH-1:0] Q,
  output logic             sOutR,
  output logic             sOutL,
  output logic             busy,
  output logic             done
);
  logic [WIDTH-1:0] q_q, q_d, next_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [2:0]       op_mode;
  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  // a running burst uses its latched mode; the live mode input only drives single steps
  assign op_mode = (state_q == S_BUSY) ? mode_q : mode;
  msrr_step #(.WIDTH(WIDTH)) u_step (
    .Q    (q_q),
    .sIn  (sIn),
    .pIn  (pIn),
    .mode (op_mode),
    .nextQ(next_q)
  );
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == S_BUSY) begin
      q_d   = next_q;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      if (steps != '0) begin
        mode_d  = mode_t'(mode);
        cnt_d   = steps;
        state_d = S_BUSY;
      end else begin
        done_d = 1'b1;
      end
    end else if (en) begin
      q_d = next_q;
    end
  end
  always_ff @(posedge clc or posedge R) begin
    if (R) begin
      q_q     <= '0;
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign Q     = q_q;
  assign sOutR = q_q[0];
  assign sOutL = q_q[WIDTH-1];
  assign busy  = (state_q == S_BUSY);
  assign done  = done_q;
endmodule

// File: tb/tb_msrr_param.sv
// tb_msrr_param: directed scenario tests for msrr_param at WIDTH=8
module tb_msrr_param;
  logic       clc = 1'b0;
  logic       R = 1'b1;
  logic       sIn = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [3:0] steps = 4'd0;
  logic [7:0] pIn = 8'h00;
  logic [7:0] Q;
  logic       sOutR, sOutL, busy, done;
  int errs = 0;
  int checks = 0;
  msrr_param dut (
    .clc  (clc),
    .R    (R),
    .sIn  (sIn),
    .mode (mode),
    .en   (en),
    .start(start),
    .steps(steps),
    .pIn  (pIn),
    .Q    (Q),
    .sOutR(sOutR),
    .sOutL(sOutL),
    .busy (busy),
    .done (done)
  );
  always #5 clc = ~clc;
  task automatic tick;
    @(posedge clc);
    #1;
  endtask
  task automatic load(input logic [7:0] v);
    mode = 3'b110;
    pIn = v;
    en = 1'b1;
    start = 1'b0;
    tick();
    en = 1'b0;
    mode = 3'b000;
  endtask
  task automatic test_reset;
    tick();
    tick();
    checks++;
    if ({Q, busy, done} !== 10'b0) begin
      errs++;
      $display("FAIL reset: Q/busy/done=%h/%b/%b expected 00/0/0", Q, busy, done);
    end
    R = 1'b0;
  endtask
  task automatic test_single;
    load(8'hA5);
    checks++;
    if (Q !== 8'hA5) begin errs++; $display("FAIL single_load: Q=%h expected a5", Q); end
    mode = 3'b011;
    en = 1'b1;
    tick();
    checks++;
    if (Q !== 8'hD2 || sOutR !== 1'b0 || sOutL !== 1'b1) begin
      errs++;
      $display("FAIL single_ror: Q=%h sOutR=%b sOutL=%b expected d2 0 1", Q, sOutR, sOutL);
    end
    mode = 3'b000;
    tick();
    checks++;
    if (Q !== 8'hD2) begin errs++; $display("FAIL single_hold: Q=%h expected d2", Q); end
    en = 1'b0;
    mode = 3'b100;
    tick();
    checks++;
    if (Q !== 8'hD2) begin errs++; $display("FAIL en_low_hold: Q=%h expected d2", Q); end
  endtask
  task automatic test_rol_burst;
    logic [9:0] exp_v [4] = '{{8'h03, 2'b10}, {8'h06, 2'b10}, {8'h0C, 2'b01}, {8'h0C, 2'b00}};
    load(8'h81);
    start = 1'b1;
    steps = 4'd3;
    mode = 3'b100;
    tick();
    checks++;
    if ({Q, busy, done} !== {8'h81, 2'b10}) begin
      errs++;
      $display("FAIL rol_start: Q/busy/done=%h/%b/%b expected 81/1/0", Q, busy, done);
    end
    start = 1'b0;
    mode = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({Q, busy, done} !== exp_v[i]) begin
        errs++;
        $display("FAIL rol_burst[%0d]: Q/busy/done=%h/%b/%b expected %h/%b/%b", i, Q, busy, done,
                 exp_v[i][9:2], exp_v[i][1], exp_v[i][0]);
      end
    end
  endtask
  task automatic test_asr;
    load(8'h90);
    start = 1'b1;
    steps = 4'd2;
    mode = 3'b101;
    sIn = 1'b0;
    tick();
    start = 1'b0;
    sIn = 1'b1;
    tick();
    checks++;
    if ({Q, busy, done} !== {8'hC8, 2'b10}) begin
      errs++;
      $display("FAIL asr_1: Q/busy/done=%h/%b/%b expected c8/1/0", Q, busy, done);
    end
    sIn = 1'b0;
    tick();
    checks++;
    if ({Q, busy, done} !== {8'hE4, 2'b01}) begin
      errs++;
      $display("FAIL asr_2: Q/busy/done=%h/%b/%b expected e4/0/1", Q, busy, done);
    end
  endtask
  task automatic test_shr_zero;
    mode = 3'b111;
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (Q !== 8'h00) begin errs++; $display("FAIL clr: Q=%h expected 00", Q); end
    sIn = 1'b1;
    start = 1'b1;
    steps = 4'd8;
    mode = 3'b001;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({Q, busy, done} !== {8'hFE, 2'b10}) begin
      errs++;
      $display("FAIL shr_7: Q/busy/done=%h/%b/%b expected fe/1/0", Q, busy, done);
    end
    tick();
    checks++;
    if ({Q, busy, done} !== {8'hFF, 2'b01}) begin
      errs++;
      $display("FAIL shr_8: Q/busy/done=%h/%b/%b expected ff/0/1", Q, busy, done);
    end
    start = 1'b1;
    steps = 4'd0;
    mode = 3'b111;
    tick();
    start = 1'b0;
    checks++;
    if ({Q, busy, done} !== {8'hFF, 2'b01}) begin
      errs++;
      $display("FAIL zero_steps: Q/busy/done=%h/%b/%b expected ff/0/1", Q, busy, done);
    end
    tick();
    checks++;
    if ({Q, busy, done} !== {8'hFF, 2'b00}) begin
      errs++;
      $display("FAIL zero_after: Q/busy/done=%h/%b/%b expected ff/0/0", Q, busy, done);
    end
  endtask
  task automatic test_priority_back_to_back;
    load(8'h01);
    sIn = 1'b0;
    start = 1'b1;
    en = 1'b1;
    steps = 4'd2;
    mode = 3'b010;
    tick();
    checks++;
    if ({Q, busy, done} !== {8'h01, 2'b10}) begin
      errs++;
      $display("FAIL prio_start: Q/busy/done=%h/%b/%b expected 01/1/0", Q, busy, done);
    end
    mode = 3'b111;
    steps = 4'd7;
    tick();
    checks++;
    if ({Q, busy, done} !== {8'h02, 2'b10}) begin
      errs++;
      $display("FAIL prio_busy: Q/busy/done=%h/%b/%b expected 02/1/0", Q, busy, done);
    end
    tick();
    checks++;
    if ({Q, busy, done} !== {8'h04, 2'b01}) begin
      errs++;
      $display("FAIL prio_done: Q/busy/done=%h/%b/%b expected 04/0/1", Q, busy, done);
    end
    en = 1'b0;
    steps = 4'd1;
    mode = 3'b100;
    tick();
    start = 1'b0;
    checks++;
    if ({Q, busy, done} !== {8'h04, 2'b10}) begin
      errs++;
      $display("FAIL b2b_start: Q/busy/done=%h/%b/%b expected 04/1/0", Q, busy, done);
    end
    tick();
    checks++;
    if ({Q, busy, done} !== {8'h08, 2'b01}) begin
      errs++;
      $display("FAIL b2b_done: Q/busy/done=%h/%b/%b expected 08/0/1", Q, busy, done);
    end
  endtask
  task automatic test_reset_mid;
    load(8'h55);
    start = 1'b1;
    steps = 4'd5;
    mode = 3'b011;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({Q, busy} !== {8'hAA, 1'b1}) begin
      errs++;
      $display("FAIL mid_pre: Q/busy=%h/%b expected aa/1", Q, busy);
    end
    #2 R = 1'b1;
    #1;
    checks++;
    if ({Q, busy, done} !== 10'b0) begin
      errs++;
      $display("FAIL mid_reset: Q/busy/done=%h/%b/%b expected 00/0/0", Q, busy, done);
    end
    start = 1'b1;
    en = 1'b1;
    tick();
    @(negedge clc);
    R = 1'b0;
    start = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({Q, busy, done} !== 10'b0) begin
        errs++;
        $display("FAIL post_reset[%0d]: Q/busy/done=%h/%b/%b expected 00/0/0", i, Q, busy, done);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rol_burst();
    test_asr();
    test_shr_zero();
    test_priority_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
